// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t      - arbiter FSM state encoding (3 bits)
//   TIMEOUT_DEFAULT  - default watchdog limit in access cycles (0 = off)
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ACC  = 3'd1,
    D_ACC  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } arb_state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// arb_watchdog: loadable down-counter that flags a memory access which has
// waited TIMEOUT cycles without completing.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : reload the counter with TIMEOUT (access start)
//   clr        : force the counter to zero (no access in flight)
//   en         : count one access cycle
//   expired    : high during the TIMEOUT-th counted cycle; never high when
//                TIMEOUT is 0
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT);
    end else if (clr) begin
      count <= '0;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  // The counter holds TIMEOUT in the first access cycle, so it reads 1 in
  // the TIMEOUT-th cycle; that is the cycle in which the access is aborted.
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = en && (count == CNT_W'(1));
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the core's
// instruction-fetch and data-access sides. Data side has fixed priority.
// Each access: IDLE -> x_ACC (strobe held until mem_ready or watchdog)
// -> x_DONE (one cycle, matching stall low) -> IDLE.
//
// Handshake: the core holds x_req high and waits while x_stall is high;
// the single cycle with x_req=1 and x_stall=0 completes its access. Toward
// memory, mem_read/mem_write are held with a stable mem_addr/mem_wdata until
// a one-cycle mem_ready pulse; mem_rdata is sampled with that pulse.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_req, i_addr                   fetch request / byte address
//   i_rdata, i_stall                fetched word (registered), fetch stall
//   d_req, d_wen, d_addr, d_wdata   data request, store flag, address, data
//   d_rdata, d_stall                load word (registered), data stall
//   mem_read, mem_write             level-held memory strobes
//   mem_addr, mem_wdata             memory word address / write data
//   mem_rdata, mem_ready            memory read data / completion pulse
//   err                             sticky watchdog timeout flag
//   dbg_state                       current FSM state
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output arb_state_t        dbg_state
);

  arb_state_t        state, state_nxt;
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [31:0]       wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic              err_nxt;
  logic              wd_load, wd_clr, wd_en, wd_expired;

  // Byte-lane bits and bits above the word address are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_read  <= read_nxt;
      mem_write <= write_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    read_nxt    = mem_read;
    write_nxt   = mem_write;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    err_nxt     = err;
    wd_load     = 1'b0;
    wd_clr      = 1'b0;
    wd_en       = 1'b0;
    case (state)
      IDLE: begin
        wd_clr = 1'b1;
        // The data access belongs to an instruction already fetched, so it
        // must drain before the next fetch or the core would deadlock.
        if (d_req) begin
          state_nxt = D_ACC;
          addr_nxt  = d_addr[ADDR_W+1:2];
          wdata_nxt = d_wdata;
          read_nxt  = ~d_wen;
          write_nxt = d_wen;
          wd_load   = 1'b1;
        end else if (i_req) begin
          state_nxt = I_ACC;
          addr_nxt  = i_addr[ADDR_W+1:2];
          wdata_nxt = d_wdata;
          read_nxt  = 1'b1;
          write_nxt = 1'b0;
          wd_load   = 1'b1;
        end
      end
      I_ACC: begin
        wd_en = 1'b1;
        if (mem_ready) begin
          read_nxt    = 1'b0;
          write_nxt   = 1'b0;
          i_rdata_nxt = mem_rdata;
          state_nxt   = I_DONE;
        end else if (wd_expired) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = I_DONE;
        end
      end
      D_ACC: begin
        wd_en = 1'b1;
        if (mem_ready) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          if (!mem_write) d_rdata_nxt = mem_rdata;
          state_nxt = D_DONE;
        end else if (wd_expired) begin
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = D_DONE;
        end
      end
      I_DONE, D_DONE: begin
        wd_clr    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        wd_clr    = 1'b1;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign i_stall   = i_req & (state != I_DONE);
  assign d_stall   = d_req & (state != D_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [31:0]       i_addr = '0;
  logic [31:0]       i_rdata;
  logic              i_stall;
  logic              d_req = 1'b0;
  logic              d_wen = 1'b0;
  logic [31:0]       d_addr = '0;
  logic [31:0]       d_wdata = '0;
  logic [31:0]       d_rdata;
  logic              d_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              err;
  arb_state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
    n_checks++; if ({mem_read, mem_write, err} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {mem_read, mem_write, err}); end
    n_checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata); end
    n_checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h %h want 0 0", i_rdata, d_rdata); end
    n_checks++; if ({i_stall, d_stall} !== 2'b00) begin n_errors++; $display("FAIL reset_stalls: got %b want 00", {i_stall, d_stall}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spurious_ready();
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL spur_state: got %0d want %0d", dbg_state, IDLE); end
    n_checks++; if ({mem_read, mem_write} !== 2'b00) begin n_errors++; $display("FAIL spur_strobes: got %b want 00", {mem_read, mem_write}); end
    n_checks++; if ({i_stall, d_stall} !== 2'b00) begin n_errors++; $display("FAIL spur_stalls: got %b want 00", {i_stall, d_stall}); end
    n_checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_errors++; $display("FAIL spur_rdata: got %h %h want 0 0", i_rdata, d_rdata); end
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_i_only();
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    #1;
    n_checks++; if (i_stall !== 1'b1) begin n_errors++; $display("FAIL ionly_stall_idle: got %b want 1", i_stall); end
    tick();
    n_checks++; if (dbg_state !== I_ACC || mem_read !== 1'b1 || mem_write !== 1'b0) begin n_errors++; $display("FAIL ionly_strobe1: got st %0d r %b w %b want 1 1 0", dbg_state, mem_read, mem_write); end
    n_checks++; if (mem_addr !== 30'd4) begin n_errors++; $display("FAIL ionly_addr: got %h want 4", mem_addr); end
    tick();
    n_checks++; if (mem_read !== 1'b1 || i_stall !== 1'b1) begin n_errors++; $display("FAIL ionly_strobe2: got r %b stall %b want 1 1", mem_read, i_stall); end
    mem_ready = 1'b1;
    mem_rdata = 32'h1300_0000;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_checks++; if (mem_read !== 1'b0) begin n_errors++; $display("FAIL ionly_strobe_drop: got %b want 0", mem_read); end
    n_checks++; if (i_rdata !== 32'h1300_0000) begin n_errors++; $display("FAIL ionly_rdata: got %h want 13000000", i_rdata); end
    n_checks++; if (i_stall !== 1'b0 || dbg_state !== I_DONE) begin n_errors++; $display("FAIL ionly_done: got stall %b st %0d want 0 %0d", i_stall, dbg_state, I_DONE); end
    tick();
    n_checks++; if (i_stall !== 1'b1 || dbg_state !== IDLE) begin n_errors++; $display("FAIL ionly_one_cycle: got stall %b st %0d want 1 %0d", i_stall, dbg_state, IDLE); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;
    d_req  = 1'b1;
    d_wen  = 1'b0;
    d_addr = 32'h0000_0080;
    tick();
    n_checks++; if (dbg_state !== D_ACC || mem_addr !== 30'h20) begin n_errors++; $display("FAIL sim_d_first: got st %0d addr %h want %0d 20", dbg_state, mem_addr, D_ACC); end
    n_checks++; if ({mem_read, mem_write} !== 2'b10) begin n_errors++; $display("FAIL sim_d_load_strobes: got %b want 10", {mem_read, mem_write}); end
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_checks++; if (d_rdata !== 32'hCAFE_F00D || d_stall !== 1'b0) begin n_errors++; $display("FAIL sim_d_done: got rdata %h stall %b want cafef00d 0", d_rdata, d_stall); end
    n_checks++; if (i_stall !== 1'b1) begin n_errors++; $display("FAIL sim_i_held: got %b want 1", i_stall); end
    d_req = 1'b0;
    tick();
    n_checks++; if (dbg_state !== IDLE || i_stall !== 1'b1 || mem_read !== 1'b0) begin n_errors++; $display("FAIL sim_idle_gap: got st %0d stall %b r %b want %0d 1 0", dbg_state, i_stall, mem_read, IDLE); end
    tick();
    n_checks++; if (dbg_state !== I_ACC || mem_addr !== 30'h40 || mem_read !== 1'b1) begin n_errors++; $display("FAIL sim_i_grant: got st %0d addr %h r %b want %0d 40 1", dbg_state, mem_addr, mem_read, I_ACC); end
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_checks++; if (i_rdata !== 32'h1122_3344 || i_stall !== 1'b0) begin n_errors++; $display("FAIL sim_i_done: got rdata %h stall %b want 11223344 0", i_rdata, i_stall); end
    n_checks++; if (d_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL sim_d_rdata_kept: got %h want cafef00d", d_rdata); end
    i_req = 1'b0;
    tick();
  endtask

  task automatic test_d_store();
    d_req   = 1'b1;
    d_wen   = 1'b1;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'hAABB_CCDD;
    tick();
    n_checks++; if ({mem_read, mem_write} !== 2'b01) begin n_errors++; $display("FAIL st_strobes: got %b want 01", {mem_read, mem_write}); end
    n_checks++; if (mem_addr !== 30'h10 || mem_wdata !== 32'hAABB_CCDD) begin n_errors++; $display("FAIL st_bus: got addr %h wdata %h want 10 aabbccdd", mem_addr, mem_wdata); end
    n_checks++; if (d_stall !== 1'b1) begin n_errors++; $display("FAIL st_stall: got %b want 1", d_stall); end
    mem_ready = 1'b1;
    mem_rdata = 32'h9999_9999;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    n_checks++; if ({mem_read, mem_write} !== 2'b00 || d_stall !== 1'b0) begin n_errors++; $display("FAIL st_done: got strobes %b stall %b want 00 0", {mem_read, mem_write}, d_stall); end
    n_checks++; if (d_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL st_rdata_kept: got %h want cafef00d", d_rdata); end
    d_req = 1'b0;
    d_wen = 1'b0;
    tick();
    n_checks++; if (dbg_state !== IDLE || err !== 1'b0) begin n_errors++; $display("FAIL st_idle: got st %0d err %b want %0d 0", dbg_state, err, IDLE); end
  endtask

  task automatic test_timeout();
    i_req  = 1'b1;
    i_addr = 32'h0000_0200;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++; if (mem_read !== 1'b1) begin n_errors++; $display("FAIL to_strobe_c%0d: got %b want 1", k + 1, mem_read); end
    end
    tick();
    n_checks++; if (mem_read !== 1'b0 || err !== 1'b1) begin n_errors++; $display("FAIL to_abort: got r %b err %b want 0 1", mem_read, err); end
    n_checks++; if (i_stall !== 1'b0 || dbg_state !== I_DONE) begin n_errors++; $display("FAIL to_release: got stall %b st %0d want 0 %0d", i_stall, dbg_state, I_DONE); end
    n_checks++; if (i_rdata !== 32'h1122_3344) begin n_errors++; $display("FAIL to_rdata_kept: got %h want 11223344", i_rdata); end
    i_req = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if (err !== 1'b1 || dbg_state !== IDLE) begin n_errors++; $display("FAIL to_err_sticky: got err %b st %0d want 1 %0d", err, dbg_state, IDLE); end
  endtask

  task automatic test_reset_mid_access();
    d_req  = 1'b1;
    d_wen  = 1'b0;
    d_addr = 32'h0000_0300;
    tick();
    n_checks++; if (dbg_state !== D_ACC || mem_read !== 1'b1) begin n_errors++; $display("FAIL rma_in_access: got st %0d r %b want %0d 1", dbg_state, mem_read, D_ACC); end
    rst_n = 1'b0;
    d_req = 1'b0;
    tick();
    n_checks++; if (dbg_state !== IDLE || {mem_read, mem_write, err} !== 3'b000) begin n_errors++; $display("FAIL rma_reset: got st %0d flags %b want %0d 000", dbg_state, {mem_read, mem_write, err}, IDLE); end
    n_checks++; if (mem_addr !== '0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_errors++; $display("FAIL rma_regs: got addr %h i %h d %h want 0 0 0", mem_addr, i_rdata, d_rdata); end
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    tick();
    n_checks++; if (dbg_state !== IDLE || d_rdata !== 32'h0 || mem_read !== 1'b0) begin n_errors++; $display("FAIL rma_late_ready: got st %0d d %h r %b want %0d 0 0", dbg_state, d_rdata, mem_read, IDLE); end
  endtask

  initial begin
    test_reset();
    test_spurious_ready();
    test_i_only();
    test_simultaneous();
    test_d_store();
    test_timeout();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
